// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and frame constants.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} uart_tx_state_t;
    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam int   UART_FRAME_BITS = 10;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: free-running bit-period counter; tick marks the last cycle of each period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == W'(CLKS_PER_BIT - 1);
    always_comb cnt_d = (clear || tick) ? '0 : cnt_q + W'(1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from a registered-read FIFO and sends them as 8N1 frames.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);
    uart_tx_state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic tx_q, tx_d, busy_q, busy_d, tick;
    assign tx   = tx_q;
    assign busy = busy_q;
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == LOAD),
        .tick (tick)
    );
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_rd_en) state_d = LOAD;
            LOAD:    state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (tick && bit_q == 3'(DATA_WIDTH - 1)) state_d = STOP;
            STOP:    if (tick) state_d = fifo_rd_en ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Strobe is masked during reset so a held reset never pops the FIFO.
    always_comb begin
        tx_done    = state_q == STOP && tick;
        fifo_rd_en = !rst && tx_en && !fifo_empty && (state_q == IDLE || tx_done);
    end
    // tx/busy are registered from next-state so the line changes on the state boundary.
    always_comb begin
        shift_d = state_q == LOAD ? fifo_data : (state_q == DATA && tick) ? shift_q >> 1 : shift_q;
        bit_d   = state_q == LOAD ? 3'd0 : (state_q == DATA && tick) ? bit_q + 3'd1 : bit_q;
        tx_d    = state_d == START ? UART_START_BIT : state_d == DATA ? shift_d[0] : UART_STOP_BIT;
        busy_d  = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= UART_STOP_BIT;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end
endmodule
